// File: rtl/ip_tx_pkg.sv
// rtl/ip_tx_pkg.sv - shared IPv4 TX constants, FSM encoding, latched header struct and checksum fold
package ip_tx_pkg;

    localparam int unsigned IP_IHL_MIN = 5;
    localparam logic [3:0]  IP_VER4    = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FOLD = 2'd2,
        SEND = 2'd3
    } ip_tx_state_e;

    // Field order matches the wire order, so word i is bits [159-32*i -: 32]
    typedef struct packed {
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [7:0]  dsf;
        logic [15:0] total_len;
        logic [15:0] id;
        logic [2:0]  flag;
        logic [12:0] frag_offset;
        logic [7:0]  ttl;
        logic [7:0]  prot;
        logic [15:0] chksum;
        logic [31:0] src;
        logic [31:0] dst;
    } ip_hdr_t;

    // Two end-around-carry folds are enough for any 21-bit sum
    function automatic logic [15:0] ones_fold16(input logic [20:0] acc);
        logic [16:0] s1;
        logic [16:0] s2;
        s1 = {1'b0, acc[15:0]} + {12'd0, acc[20:16]};
        s2 = {1'b0, s1[15:0]} + {16'd0, s1[16]};
        return s2[15:0];
    endfunction

endpackage

// File: rtl/ip_chksum_acc.sv
// rtl/ip_chksum_acc.sv - 21-bit one's-complement accumulator: clear, add both halves of a 32-bit word, fold
module ip_chksum_acc
    import ip_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add,
    input  logic [31:0] word,
    output logic [20:0] sum,
    output logic [15:0] folded
);

    logic [20:0] sum_q;
    logic [20:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (add) begin
            sum_d = sum_q + {5'd0, word[31:16]} + {5'd0, word[15:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum    = sum_q;
    assign folded = ones_fold16(sum_q);

endmodule

// File: rtl/ip_header_tx.sv
// rtl/ip_header_tx.sv - IPv4 header streamer; define IP_TX_CHKSUM_EN to compute the header checksum
// internally (CALC/FOLD states), otherwise ip_head_chksum is sent as given.
module ip_header_tx
    import ip_tx_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int OPT_WORDS_MAX = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ip_start,
    input  logic [3:0]            ip_version,
    input  logic [3:0]            ip_head_len,
    input  logic [7:0]            ip_dsf,
    input  logic [15:0]           ip_total_len,
    input  logic [15:0]           ip_id,
    input  logic [2:0]            ip_flag,
    input  logic [12:0]           ip_frag_offset,
    input  logic [7:0]            ip_ttl,
    input  logic [7:0]            ip_prot,
    input  logic [15:0]           ip_head_chksum,
    input  logic [31:0]           ip_src_addr,
    input  logic [31:0]           ip_dst_addr,
    input  logic [32*((OPT_WORDS_MAX > 0) ? OPT_WORDS_MAX : 1)-1:0] ip_options,
    output logic                  ip_busy,
    output logic                  ip_err,
    output logic [DATA_W-1:0]     out_data,
    output logic [DATA_W/8-1:0]   out_be,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop
);

    localparam int WPB   = DATA_W / 32;
    localparam int BSH   = (DATA_W == 64) ? 1 : 0;
    localparam int OPT_W = (OPT_WORDS_MAX > 0) ? OPT_WORDS_MAX : 1;
    localparam logic [4:0] IHL_LO = 5'(IP_IHL_MIN);
    localparam logic [4:0] IHL_HI = 5'(IP_IHL_MIN + OPT_WORDS_MAX);
`ifdef IP_TX_CHKSUM_EN
    localparam ip_tx_state_e FIRST_ST = CALC;
`else
    localparam ip_tx_state_e FIRST_ST = SEND;
`endif

    ip_tx_state_e       state_q, state_d;
    ip_hdr_t            hdr_q, hdr_d;
    logic [32*OPT_W-1:0] opt_q, opt_d;
    logic [3:0]         idx_q, idx_d;
    logic               err_q, err_d;

    logic        ihl_ok, accept, reject, xfer;
    logic        calc_last, send_last;
    logic [3:0]  last_idx;
    logic [31:0] hdr_w [16];
    logic [4:0]  widx;

    assign ihl_ok    = ({1'b0, ip_head_len} >= IHL_LO) && ({1'b0, ip_head_len} <= IHL_HI);
    assign accept    = ip_start && (state_q == IDLE) && ihl_ok;
    assign reject    = ip_start && (state_q == IDLE) && !ihl_ok;
    assign xfer      = (state_q == SEND) && out_ready;
    assign last_idx  = (hdr_q.ihl - 4'd1) >> BSH;
    assign calc_last = (idx_q == hdr_q.ihl - 4'd1);
    assign send_last = (idx_q == last_idx);

    // The checksum field holds 0 while CALC walks the words, so it drops out of the sum
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            hdr_w[i] = '0;
        end
        for (int i = 0; i < 5; i++) begin
            hdr_w[i] = hdr_q[32*(4-i) +: 32];
        end
        for (int j = 0; j < OPT_WORDS_MAX; j++) begin
            hdr_w[5+j] = opt_q[32*(OPT_W-1-j) +: 32];
        end
    end

`ifdef IP_TX_CHKSUM_EN
    logic [20:0] acc_sum;
    logic [15:0] acc_fold;
    logic        unused_ext;

    ip_chksum_acc u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .add    (state_q == CALC),
        .word   (hdr_w[idx_q]),
        .sum    (acc_sum),
        .folded (acc_fold)
    );

    assign unused_ext = ^{ip_head_chksum, acc_sum};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = FIRST_ST;
            CALC:    if (calc_last) state_d = FOLD;
            FOLD:    state_d = SEND;
            SEND:    if (xfer && send_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hdr_d = hdr_q;
        opt_d = opt_q;
        idx_d = idx_q;
        err_d = reject;
        if (accept) begin
            hdr_d.version     = ip_version;
            hdr_d.ihl         = ip_head_len;
            hdr_d.dsf         = ip_dsf;
            hdr_d.total_len   = ip_total_len;
            hdr_d.id          = ip_id;
            hdr_d.flag        = ip_flag;
            hdr_d.frag_offset = ip_frag_offset;
            hdr_d.ttl         = ip_ttl;
            hdr_d.prot        = ip_prot;
`ifdef IP_TX_CHKSUM_EN
            hdr_d.chksum      = '0;
`else
            hdr_d.chksum      = ip_head_chksum;
`endif
            hdr_d.src         = ip_src_addr;
            hdr_d.dst         = ip_dst_addr;
            opt_d             = ip_options;
            idx_d             = '0;
        end
        case (state_q)
            CALC: idx_d = calc_last ? 4'd0 : idx_q + 4'd1;
`ifdef IP_TX_CHKSUM_EN
            FOLD: hdr_d.chksum = ~acc_fold;
`endif
            SEND: if (xfer) idx_d = send_last ? 4'd0 : idx_q + 4'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q <= '0;
            opt_q <= '0;
            idx_q <= '0;
            err_q <= 1'b0;
        end else begin
            hdr_q <= hdr_d;
            opt_q <= opt_d;
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end

    // Beat content depends only on registered state, so it holds across stalls
    always_comb begin
        ip_busy   = (state_q != IDLE);
        ip_err    = err_q;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_data  = '0;
        out_be    = '0;
        widx      = '0;
        if (state_q == SEND) begin
            out_valid = 1'b1;
            out_sop   = (idx_q == 4'd0);
            out_eop   = send_last;
            for (int w = 0; w < WPB; w++) begin
                widx = 5'({1'b0, idx_q} << BSH) + 5'(w);
                if (widx < {1'b0, hdr_q.ihl}) begin
                    out_data[DATA_W-1-32*w -: 32] = hdr_w[widx[3:0]];
                    out_be[DATA_W/8-1-4*w -: 4]   = 4'hF;
                end
            end
        end
    end

endmodule

// File: tb/tb_ip_header_tx.sv
// tb/tb_ip_header_tx.sv - directed bench for ip_header_tx at DATA_W=32 and DATA_W=64
module tb_ip_header_tx;

`ifdef IP_TX_CHKSUM_EN
    localparam bit          CK  = 1'b1;
    localparam logic [15:0] CS5 = 16'hb861;
    localparam logic [15:0] CS6 = 16'hb35b;
`else
    localparam bit          CK  = 1'b0;
    localparam logic [15:0] CS5 = 16'h1234;
    localparam logic [15:0] CS6 = 16'h1234;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start32, start64, ready32, ready64;
    logic [3:0]  ip_version, ip_head_len;
    logic [7:0]  ip_dsf, ip_ttl, ip_prot;
    logic [15:0] ip_total_len, ip_id, ip_head_chksum;
    logic [2:0]  ip_flag;
    logic [12:0] ip_frag_offset;
    logic [31:0] ip_src_addr, ip_dst_addr, ip_options;

    logic        busy32, err32, v32, sop32, eop32;
    logic [31:0] d32;
    logic [3:0]  be32;
    logic        busy64, err64, v64, sop64, eop64;
    logic [63:0] d64;
    logic [7:0]  be64;

    logic        o_valid, o_sop, o_eop, o_busy;
    logic [63:0] o_data;
    logic [7:0]  o_be;

    logic [63:0] exp_beat [8];
    logic [7:0]  exp_be   [8];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ip_header_tx #(.DATA_W(32), .OPT_WORDS_MAX(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .ip_start(start32), .ip_version(ip_version),
        .ip_head_len(ip_head_len), .ip_dsf(ip_dsf), .ip_total_len(ip_total_len), .ip_id(ip_id),
        .ip_flag(ip_flag), .ip_frag_offset(ip_frag_offset), .ip_ttl(ip_ttl), .ip_prot(ip_prot),
        .ip_head_chksum(ip_head_chksum), .ip_src_addr(ip_src_addr), .ip_dst_addr(ip_dst_addr),
        .ip_options(ip_options), .ip_busy(busy32), .ip_err(err32), .out_data(d32), .out_be(be32),
        .out_valid(v32), .out_ready(ready32), .out_sop(sop32), .out_eop(eop32)
    );

    ip_header_tx #(.DATA_W(64), .OPT_WORDS_MAX(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .ip_start(start64), .ip_version(ip_version),
        .ip_head_len(ip_head_len), .ip_dsf(ip_dsf), .ip_total_len(ip_total_len), .ip_id(ip_id),
        .ip_flag(ip_flag), .ip_frag_offset(ip_frag_offset), .ip_ttl(ip_ttl), .ip_prot(ip_prot),
        .ip_head_chksum(ip_head_chksum), .ip_src_addr(ip_src_addr), .ip_dst_addr(ip_dst_addr),
        .ip_options(ip_options), .ip_busy(busy64), .ip_err(err64), .out_data(d64), .out_be(be64),
        .out_valid(v64), .out_ready(ready64), .out_sop(sop64), .out_eop(eop64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic snap(input bit w64);
        o_valid = w64 ? v64 : v32;
        o_sop   = w64 ? sop64 : sop32;
        o_eop   = w64 ? eop64 : eop32;
        o_busy  = w64 ? busy64 : busy32;
        o_data  = w64 ? d64 : {32'd0, d32};
        o_be    = w64 ? be64 : {4'd0, be32};
    endtask

    function automatic int lat_for(input int ihl);
        return CK ? ihl + 2 : 1;
    endfunction

    // Entered at a falling edge; lat0 is how many falling edges have passed since the start was sampled
    task automatic rx(input bit w64, input string tag, input int lat0, input int lat_exp,
                      input int nbeats, input logic [7:0] pat);
        int   lat;
        int   nb;
        int   cyc;
        logic r;
        lat = lat0;
        snap(w64);
        while (!o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            snap(w64);
        end
        if (lat_exp > 0) chk({tag, " latency"}, 64'(lat), 64'(lat_exp));
        nb  = 0;
        cyc = 0;
        while (nb < nbeats && cyc < 64) begin
            r = pat[cyc % 8];
            if (w64) ready64 = r; else ready32 = r;
            snap(w64);
            chk($sformatf("%s b%0d valid", tag, nb), {63'd0, o_valid}, 64'd1);
            chk($sformatf("%s b%0d data", tag, nb), o_data, exp_beat[nb]);
            chk($sformatf("%s b%0d be", tag, nb), {56'd0, o_be}, {56'd0, exp_be[nb]});
            chk($sformatf("%s b%0d sop", tag, nb), {63'd0, o_sop}, {63'd0, nb == 0});
            chk($sformatf("%s b%0d eop", tag, nb), {63'd0, o_eop}, {63'd0, nb == nbeats - 1});
            if (r) nb++;
            cyc++;
            @(negedge clk);
        end
        snap(w64);
        chk({tag, " beat count"}, 64'(nb), 64'(nbeats));
        chk({tag, " busy released"}, {63'd0, o_busy}, 64'd0);
        chk({tag, " valid released"}, {63'd0, o_valid}, 64'd0);
        ready32 = 1'b1;
        ready64 = 1'b1;
    endtask

    task automatic set_exp32(input logic [15:0] cs);
        exp_beat[0] = {32'd0, 32'h4500_0073};
        exp_beat[1] = {32'd0, 32'h0000_4000};
        exp_beat[2] = {32'd0, 8'h40, 8'h11, cs};
        exp_beat[3] = {32'd0, 32'hc0a8_0001};
        exp_beat[4] = {32'd0, 32'hc0a8_00c7};
        for (int i = 0; i < 8; i++) exp_be[i] = 8'h0F;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start32 = 1'b0; start64 = 1'b0; ready32 = 1'b1; ready64 = 1'b1;
        ip_version = 4'd4; ip_head_len = 4'd5; ip_dsf = 8'h00; ip_total_len = 16'h0073;
        ip_id = 16'h0000; ip_flag = 3'b010; ip_frag_offset = 13'd0; ip_ttl = 8'h40;
        ip_prot = 8'h11; ip_head_chksum = 16'h1234; ip_src_addr = 32'hc0a8_0001;
        ip_dst_addr = 32'hc0a8_00c7; ip_options = 32'h0102_0304;
        repeat (2) @(negedge clk);
        snap(1'b0);
        chk("reset busy", {63'd0, o_busy}, 64'd0);
        chk("reset err", {63'd0, err32}, 64'd0);
        chk("reset valid", {63'd0, o_valid}, 64'd0);
        chk("reset data", o_data, 64'd0);
        chk("reset be", {56'd0, o_be}, 64'd0);
        chk("reset sop/eop", {62'd0, o_sop, o_eop}, 64'd0);
        chk("reset 64 valid/data", {v64, d64[62:0]}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic header, DATA_W=32, sink always ready
        set_exp32(CS5);
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        rx(1'b0, "A", 1, lat_for(5), 5, 8'hFF);

        // Start on the idle cycle right after EOP, then a start while busy must be ignored
        start32 = 1'b1;
        ready32 = 1'b0;
        @(negedge clk);
        start32 = 1'b0;
        chk("B2B accepted", {63'd0, busy32}, 64'd1);
        ip_head_len = 4'd4;
        ip_id = 16'hdead;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        chk("busy start no err", {63'd0, err32}, 64'd0);
        ip_head_len = 4'd5;
        ip_id = 16'h0000;
        rx(1'b0, "C stall", 2, 0, 5, 8'b1001_1001);

        // Illegal IHL below and above the legal range
        ip_head_len = 4'd4;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        chk("ihl4 err", {63'd0, err32}, 64'd1);
        chk("ihl4 busy", {63'd0, busy32}, 64'd0);
        @(negedge clk);
        chk("ihl4 err pulse", {63'd0, err32}, 64'd0);
        ip_head_len = 4'd7;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        chk("ihl7 err", {63'd0, err32}, 64'd1);
        chk("ihl7 busy", {63'd0, busy32}, 64'd0);
        @(negedge clk);
        chk("ihl7 err pulse", {63'd0, err32}, 64'd0);
        chk("ihl7 no valid", {63'd0, v32}, 64'd0);

        // DATA_W=64, odd IHL: last beat half-filled
        ip_head_len = 4'd5;
        exp_beat[0] = {32'h4500_0073, 32'h0000_4000};
        exp_beat[1] = {8'h40, 8'h11, CS5, 32'hc0a8_0001};
        exp_beat[2] = {32'hc0a8_00c7, 32'h0000_0000};
        exp_be[0] = 8'hFF; exp_be[1] = 8'hFF; exp_be[2] = 8'hF0;
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        rx(1'b1, "E ihl5", 1, lat_for(5), 3, 8'hFF);

        // DATA_W=64, IHL=6 with one option word
        ip_head_len = 4'd6;
        exp_beat[0] = {32'h4600_0073, 32'h0000_4000};
        exp_beat[1] = {8'h40, 8'h11, CS6, 32'hc0a8_0001};
        exp_beat[2] = {32'hc0a8_00c7, 32'h0102_0304};
        exp_be[0] = 8'hFF; exp_be[1] = 8'hFF; exp_be[2] = 8'hFF;
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        rx(1'b1, "E ihl6", 1, lat_for(6), 3, 8'hFF);

        // Reset while beat 2 is on the bus, then a clean header
        ip_head_len = 4'd5;
        set_exp32(CS5);
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        for (int i = 0; i < 40 && !v32; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("F beat2 data", {32'd0, d32}, exp_beat[2]);
        rst_n = 1'b0;
        #1;
        chk("F rst valid", {63'd0, v32}, 64'd0);
        chk("F rst busy", {63'd0, busy32}, 64'd0);
        chk("F rst data", {32'd0, d32}, 64'd0);
        chk("F rst sop/eop/be", {58'd0, sop32, eop32, be32}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        rx(1'b0, "G after rst", 1, lat_for(5), 5, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
